ror_seq: RTL and testbench

ROR_SEQ -- requirements
Module: ror_seq

---
 rtl/ror_seq.sv | 90 +++++++++
 tb/tb_ror_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ror_seq.sv
// Sequential 64-bit rotate-right: three 2-bit radix-4 rotation stages, one per cycle,
// with a valid/ready handshake on both the request and result sides.
module ror_seq #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] val,
  input  logic [7:0]       r_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam int unsigned AMT_W = 6;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   work_d;
  logic [AMT_W-1:0]   amt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [AMT_W-1:0]   shamt;

  // Only the low six amount bits matter for a 64-bit rotate.
  logic [1:0] unused_rbits;
  assign unused_rbits = r_bits[7:6];

  // Stage k rotates by amount[2k+1:2k] * 4^k.
  always_comb begin
    shamt = '0;
    unique case (cnt_q)
      2'd0:    shamt = {4'b0000, amt_q[1:0]};
      2'd1:    shamt = {2'b00, amt_q[3:2], 2'b00};
      2'd2:    shamt = {amt_q[5:4], 4'b0000};
      default: shamt = '0;
    endcase
  end

  // A shift by the full width yields zero, so shamt=0 needs no special case.
  assign work_d = (work_q >> shamt) | (work_q << (7'(WIDTH) - {1'b0, shamt}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      amt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= val;
            amt_q   <= r_bits[AMT_W-1:0];
            cnt_q   <= '0;
            state_q <= ROT;
          end
        end
        ROT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 2'd1;
          if (cnt_q == 2'd2) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = (state_q == DONE) ? work_q : '0;

endmodule

// File: tb/tb_ror_seq.sv
// Self-checking bench for ror_seq: vector table, scoreboard queue, backpressure,
// reset mid-operation, operand scrambling during ROT and a rotate-left round trip.
module tb_ror_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] val;
  logic [7:0]  r_bits;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [63:0] v;
    logic [7:0]  r;
    logic [63:0] e;
    int          hold;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  ror_seq #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .val       (val),
    .r_bits    (r_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  function automatic logic [63:0] ror_ref(input logic [63:0] v, input int r);
    logic [63:0] res;
    int s;
    s = r % 64;
    for (int i = 0; i < 64; i++) res[i] = v[(i + s) % 64];
    return res;
  endfunction

  function automatic logic [63:0] rol_ref(input logic [63:0] v, input int r);
    logic [63:0] res;
    int s;
    s = r % 64;
    for (int i = 0; i < 64; i++) res[(i + s) % 64] = v[i];
    return res;
  endfunction

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input logic [63:0] v, input logic [7:0] r, input logic [63:0] e,
                        input int hold, input bit scramble);
    logic [63:0] exp_v;
    exp_v = '0;
    chk1("in_ready_idle", in_ready, 1'b1);
    in_valid  = 1'b1;
    val       = v;
    r_bits    = r;
    out_ready = (hold == 0);
    @(posedge clk);
    exp_q.push_back(e);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk1("latency_valid_low", out_valid, 1'b0);
      chk1("busy_in_rot", busy, 1'b1);
      if (scramble) begin
        in_valid = 1'b1;
        val      = {$urandom, $urandom};
        r_bits   = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk1("latency_valid_high", out_valid, 1'b1);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got output %h with no expected entry", out);
    end else begin
      exp_v = exp_q.pop_front();
      chk64("result", out, exp_v);
    end
    for (int h = 0; h < hold; h++) begin
      in_valid  = 1'b1;
      val       = {$urandom, $urandom};
      r_bits    = 8'($urandom);
      out_ready = 1'b0;
      @(negedge clk);
      chk1("hold_valid", out_valid, 1'b1);
      chk64("hold_out_stable", out, exp_v);
      chk1("hold_in_ready_low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    if (hold > 0) in_valid = 1'b1;
    @(negedge clk);
    chk1("consumed_valid_low", out_valid, 1'b0);
    chk64("consumed_out_zero", out, 64'h0);
    chk1("consumed_in_ready", in_ready, 1'b1);
    chk1("consumed_busy_low", busy, 1'b0);
    in_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] v;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    val       = '0;
    r_bits    = '0;
    out_ready = 1'b0;

    tbl[0] = '{64'h0000000000000001, 8'd1,   64'h8000000000000000, 0};
    tbl[1] = '{64'h0123456789ABCDEF, 8'd0,   64'h0123456789ABCDEF, 0};
    tbl[2] = '{64'h0123456789ABCDEF, 8'd64,  64'h0123456789ABCDEF, 0};
    tbl[3] = '{64'h0123456789ABCDEF, 8'd8,   64'hEF0123456789ABCD, 0};
    tbl[4] = '{64'h0123456789ABCDEF, 8'd200, 64'hEF0123456789ABCD, 0};
    tbl[5] = '{64'h0123456789ABCDEF, 8'd4,   64'hF0123456789ABCDE, 1};
    tbl[6] = '{64'h0000000000000001, 8'd63,  64'h0000000000000002, 2};
    tbl[7] = '{64'h8000000000000000, 8'd255, 64'h0000000000000001, 0};
    tbl[8] = '{64'hFFFF000000000000, 8'd16,  64'h0000FFFF00000000, 0};

    repeat (2) @(negedge clk);
    chk1("reset_out_valid", out_valid, 1'b0);
    chk64("reset_out", out, 64'h0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Vector table, starting on the first edge after reset release.
    for (int i = 0; i < 9; i++) run_op(tbl[i].v, tbl[i].r, tbl[i].e, tbl[i].hold, 1'b0);

    // Backpressure with a competing request held high.
    run_op(64'h0123456789ABCDEF, 8'd12, 64'hDEF0123456789ABC, 5, 1'b0);

    // Reset during the second ROT step discards the operation.
    in_valid = 1'b1;
    val      = 64'hA5A5A5A5A5A5A5A5;
    r_bits   = 8'd37;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    chk64("midrst_out", out, 64'h0);
    @(negedge clk);
    chk1("midrst_hold_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    run_op(64'hFFFF000000000000, 8'd16, 64'h0000FFFF00000000, 0, 1'b0);

    // Operands changing every cycle during ROT.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] r;
      v = {$urandom, $urandom};
      r = 8'($urandom);
      run_op(v, r, ror_ref(v, int'(r)), i % 3, 1'b1);
    end

    // Round trip through rotate-left.
    for (int r = 0; r < 64; r++) begin
      for (int k = 0; k < 100; k++) begin
        v = {$urandom, $urandom};
        run_op(rol_ref(v, r), 8'(r), v, 0, 1'b0);
      end
    end

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
